// File: rtl/plru_pkg.sv
// Shared tree-PLRU definitions for a 16-way set: sizes, FSM states, victim and touch helpers.
package plru_pkg;
  localparam int PLRU_WAYS  = 16;
  localparam int PLRU_WAY_W = 4;
  localparam int PLRU_NODES = 15;

  typedef enum logic {ST_RUN, ST_SWEEP} plru_st_e;

  // Walk from the root; a set node bit steers toward the upper half.
  function automatic logic [PLRU_WAY_W-1:0] plru_victim(input logic [PLRU_NODES-1:0] st);
    logic [PLRU_WAY_W-1:0] way;
    logic [3:0]            node;
    logic                  b;
    way  = '0;
    node = '0;
    for (int l = 0; l < PLRU_WAY_W; l++) begin
      b    = st[node];
      way  = {way[PLRU_WAY_W-2:0], b};
      node = {node[2:0], 1'b0} + 4'd1 + {3'b000, b};
    end
    return way;
  endfunction

  // Point every node on the path of 'way' away from it.
  function automatic logic [PLRU_NODES-1:0] plru_touch(input logic [PLRU_NODES-1:0] st,
                                                       input logic [PLRU_WAY_W-1:0] way);
    logic [PLRU_NODES-1:0] s;
    logic [PLRU_WAY_W-1:0] w;
    logic [3:0]            node;
    logic                  d;
    s    = st;
    w    = way;
    node = '0;
    for (int l = 0; l < PLRU_WAY_W; l++) begin
      d       = w[PLRU_WAY_W-1];
      s[node] = ~d;
      node    = {node[2:0], 1'b0} + 4'd1 + {3'b000, d};
      w       = {w[PLRU_WAY_W-2:0], 1'b0};
    end
    return s;
  endfunction
endpackage

// File: rtl/plru_tree16_calc.sv
// Combinational 16-way tree-PLRU step: victim of a state and the state after touching a way.
module plru_tree16_calc
  import plru_pkg::*;
(
  input  logic [PLRU_NODES-1:0] i_state,
  input  logic [PLRU_WAY_W-1:0] i_touch_way,
  output logic [PLRU_WAY_W-1:0] o_victim,
  output logic [PLRU_NODES-1:0] o_next
);
  assign o_victim = plru_victim(i_state);
  assign o_next   = plru_touch(i_state, i_touch_way);
endmodule

// File: rtl/plru_ctrl.sv
// Per-set 16-way tree-PLRU controller with hit touches, victim selection and a flush sweep.
// Optional PLRU_CTRL_INVALID_FIRST_EN: prefer the lowest invalid way over the tree victim.
module plru_ctrl
  import plru_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int SET_W = $clog2(SETS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  hit_valid,
  input  logic [SET_W-1:0]      hit_set,
  input  logic [PLRU_WAY_W-1:0] hit_way,
  input  logic                  vic_req_valid,
  output logic                  vic_req_ready,
  input  logic [SET_W-1:0]      vic_req_set,
  input  logic [PLRU_WAYS-1:0]  vic_req_vmask,
  output logic                  vic_resp_valid,
  output logic [PLRU_WAY_W-1:0] vic_resp_way,
  output logic                  busy
);
  logic [PLRU_NODES-1:0] r_state [SETS];
  plru_st_e              r_fsm, w_fsm_nxt;
  logic [SET_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_resp_valid;
  logic [PLRU_WAY_W-1:0] r_resp_way;

  logic                  w_vic_acc, w_hit_acc;
  logic [PLRU_WAY_W-1:0] w_tree_way, w_vic_way;
  logic [PLRU_NODES-1:0] w_vic_next, w_hit_base, w_hit_next;

  assign busy           = (r_fsm == ST_SWEEP);
  assign vic_req_ready  = ~busy;
  assign w_vic_acc      = vic_req_valid & vic_req_ready;
  assign w_hit_acc      = hit_valid & ~busy;
  assign vic_resp_valid = r_resp_valid;
  assign vic_resp_way   = r_resp_way;

  plru_tree16_calc u_calc (
    .i_state     (r_state[vic_req_set]),
    .i_touch_way (w_vic_way),
    .o_victim    (w_tree_way),
    .o_next      (w_vic_next)
  );

`ifdef PLRU_CTRL_INVALID_FIRST_EN
  always_comb begin
    w_vic_way = w_tree_way;
    if (~&vic_req_vmask) begin
      for (int i = PLRU_WAYS-1; i >= 0; i--)
        if (!vic_req_vmask[i]) w_vic_way = PLRU_WAY_W'(i);
    end
  end
`else
  logic w_unused_vmask;
  assign w_unused_vmask = ^vic_req_vmask;
  assign w_vic_way      = w_tree_way;
`endif

  // Same-set hit lands on top of the victim touch.
  assign w_hit_base = (w_vic_acc && (vic_req_set == hit_set)) ? w_vic_next : r_state[hit_set];
  assign w_hit_next = plru_touch(w_hit_base, hit_way);

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_cnt_nxt = r_cnt;
    case (r_fsm)
      ST_RUN: begin
        if (flush) begin
          w_fsm_nxt = ST_SWEEP;
          w_cnt_nxt = '0;
        end
      end
      ST_SWEEP: begin
        if (flush) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == SET_W'(SETS-1)) begin
          w_fsm_nxt = ST_RUN;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_fsm_nxt = ST_RUN;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= ST_RUN;
      r_cnt <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) r_state[s] <= '0;
    end else if (busy) begin
      r_state[r_cnt] <= '0;
    end else begin
      if (w_vic_acc) r_state[vic_req_set] <= w_vic_next;
      if (w_hit_acc) r_state[hit_set]     <= w_hit_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_way   <= '0;
    end else begin
      r_resp_valid <= w_vic_acc;
      if (w_vic_acc) r_resp_way <= w_vic_way;
    end
  end
endmodule

// File: tb/tb_plru_ctrl.sv
// Randomized self-checking bench for plru_ctrl against a per-set node-array PLRU model.
module tb_plru_ctrl;
  localparam int SETS  = 64;
  localparam int SET_W = $clog2(SETS);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             hit_valid = 1'b0;
  logic [SET_W-1:0] hit_set = '0;
  logic [3:0]       hit_way = '0;
  logic             vic_req_valid = 1'b0;
  logic             vic_req_ready;
  logic [SET_W-1:0] vic_req_set = '0;
  logic [15:0]      vic_req_vmask = 16'hFFFF;
  logic             vic_resp_valid;
  logic [3:0]       vic_resp_way;
  logic             busy;

  plru_ctrl #(.SETS(SETS), .SET_W(SET_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .hit_valid(hit_valid), .hit_set(hit_set), .hit_way(hit_way),
    .vic_req_valid(vic_req_valid), .vic_req_ready(vic_req_ready),
    .vic_req_set(vic_req_set), .vic_req_vmask(vic_req_vmask),
    .vic_resp_valid(vic_resp_valid), .vic_resp_way(vic_resp_way), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each set is a plain array of 15 tree nodes; sweep is a busy flag plus set index.
  bit mt [SETS][15];
  bit m_busy = 0;
  int m_idx  = 0;
  bit m_rv   = 0;
  int m_rw   = 0;

  function automatic int m_victim(input int s);
    int node = 0;
    int w = 0;
    for (int l = 0; l < 4; l++) begin
      int b = int'(mt[s][node]);
      w    = w * 2 + b;
      node = 2 * node + 1 + b;
    end
    return w;
  endfunction

  function automatic void m_touch(input int s, input int w);
    int node = 0;
    for (int l = 3; l >= 0; l--) begin
      int d = (w >> l) & 1;
      mt[s][node] = (d == 0);
      node = 2 * node + 1 + d;
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) for (int n = 0; n < 15; n++) mt[s][n] = 0;
      m_busy = 0; m_idx = 0; m_rv = 0; m_rw = 0;
    end else if (m_busy) begin
      for (int n = 0; n < 15; n++) mt[m_idx][n] = 0;
      m_rv = 0;
      if (flush) m_idx = 0;
      else if (m_idx == SETS-1) begin m_busy = 0; m_idx = 0; end
      else m_idx++;
    end else begin
      m_rv = vic_req_valid;
      if (vic_req_valid) begin
        int v;
        v = m_victim(int'(vic_req_set));
`ifdef PLRU_CTRL_INVALID_FIRST_EN
        for (int i = 15; i >= 0; i--) if (!vic_req_vmask[i]) v = i;
`endif
        m_touch(int'(vic_req_set), v);
        m_rw = v;
      end
      if (hit_valid) m_touch(int'(hit_set), int'(hit_way));
      if (flush) begin m_busy = 1; m_idx = 0; end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("busy", int'(busy), int'(m_busy));
    chk("ready", int'(vic_req_ready), int'(!m_busy));
    chk("resp_valid", int'(vic_resp_valid), int'(m_rv));
    if (m_rv) chk("resp_way", int'(vic_resp_way), m_rw);
  end

  task automatic clear_in();
    flush = 0; hit_valid = 0; vic_req_valid = 0; vic_req_vmask = 16'hFFFF;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 0; clear_in();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask

  task automatic vic_lit(input int s, input logic [15:0] vm, input int exp, input string name);
    @(posedge clk); #2;
    clear_in();
    vic_req_valid = 1; vic_req_set = SET_W'(s); vic_req_vmask = vm;
    @(posedge clk); #2 clear_in();
    @(negedge clk);
    chk({name, "_valid"}, int'(vic_resp_valid), 1);
    chk(name, int'(vic_resp_way), exp);
  endtask

  task automatic hit(input int s, input int w);
    @(posedge clk); #2;
    clear_in();
    hit_valid = 1; hit_set = SET_W'(s); hit_way = 4'(w);
    @(posedge clk); #2 clear_in();
  endtask

  int bcnt;

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(vic_req_ready), 1);
    chk("rst_resp_valid", int'(vic_resp_valid), 0);
    chk("rst_resp_way", int'(vic_resp_way), 0);

    vic_lit(3, 16'hFFFF, 0, "s3_v0");
    vic_lit(3, 16'hFFFF, 8, "s3_v1");
    vic_lit(3, 16'hFFFF, 4, "s3_v2");
    vic_lit(3, 16'hFFFF, 12, "s3_v3");
    hit(5, 0);
    vic_lit(5, 16'hFFFF, 8, "s5_after_hit0");

    do_reset();
    @(posedge clk); #2;
    hit_valid = 1; hit_set = 5; hit_way = 8;
    vic_req_valid = 1; vic_req_set = 5;
    @(posedge clk); #2 clear_in();
    @(negedge clk);
    chk("same_cycle_way", int'(vic_resp_way), 0);
    vic_lit(5, 16'hFFFF, 4, "same_cycle_next");

    hit(0, 3);
    hit(SETS-1, 0);
    @(posedge clk); #2 flush = 1;
    @(posedge clk); #2 flush = 0;
    hit_valid = 1; hit_set = SET_W'(SETS-1); hit_way = 15;
    bcnt = 0;
    for (int k = 0; k < SETS + 20; k++) begin
      @(negedge clk);
      if (!busy) break;
      bcnt++;
      hit_way = 4'($urandom_range(15, 0));
    end
    hit_valid = 0;
    chk("sweep_len", bcnt, SETS);
    vic_lit(SETS-1, 16'hFFFF, 0, "post_flush_vic");

    @(posedge clk); #2 flush = 1;
    @(posedge clk); #2 flush = 0;
    bcnt = 0;
    for (int k = 0; k < 2 * SETS + 40; k++) begin
      @(negedge clk);
      flush = 0;
      if (!busy) break;
      bcnt++;
      if (bcnt == 10) flush = 1;
    end
    flush = 0;
    chk("reflush_len", bcnt, 10 + SETS);

`ifdef PLRU_CTRL_INVALID_FIRST_EN
    do_reset();
    vic_lit(7, 16'hFFF7, 3, "inv_first");
    vic_lit(7, 16'hFFFF, 8, "inv_tree");
`endif

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      hit_valid     = ($urandom_range(99, 0) < 50);
      hit_set       = SET_W'($urandom_range(SETS-1, 0));
      hit_way       = 4'($urandom_range(15, 0));
      vic_req_valid = ($urandom_range(99, 0) < 50);
      vic_req_set   = ($urandom_range(3, 0) == 0) ? hit_set : SET_W'($urandom_range(SETS-1, 0));
      vic_req_vmask = ($urandom_range(1, 0) == 0) ? 16'hFFFF : 16'($urandom());
      flush         = ($urandom_range(299, 0) == 0);
    end
    @(posedge clk); #2 clear_in();
    for (int k = 0; k < 2 * SETS + 10; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("drain_idle", int'(busy), 0);

    @(posedge clk); #2 flush = 1;
    @(posedge clk); #2 flush = 0;
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(vic_req_ready), 1);
    @(posedge clk); #2 rst_n = 1;
    repeat (4) @(posedge clk);
    #2 vic_lit(9, 16'hFFFF, 0, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/plru_ctrl.md
PLRU_CTRL -- requirements
Module: plru_ctrl

Interface
REQ-001 Parameter SETS, default 64, number of sets managed (power of two, 2..256).
REQ-002 Parameter SET_W, default $clog2(SETS), set index width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  one-cycle pulse; start clearing all PLRU states.
REQ-006 hit_valid  input  1  lookup hit touch request.
REQ-007 hit_set  input  SET_W  set of the hit.
REQ-008 hit_way  input  4  way that hit.
REQ-009 vic_req_valid  input  1  refill asks for a victim.
REQ-010 vic_req_ready  output  1  victim request accepted this cycle.
REQ-011 vic_req_set  input  SET_W  set needing a victim.
REQ-012 vic_req_vmask  input  16  per-way valid bits of that set.
REQ-013 vic_resp_valid  output  1  victim result valid.
REQ-014 vic_resp_way  output  4  chosen victim way.
REQ-015 busy  output  1  flush sweep in progress.

Function
REQ-016 Each set SHALL hold a 15-bit tree-PLRU state; node 0 root, children of node i are 2i+1/2i+2; bit 0 steers victim toward lower ways.
REQ-017 Victim way SHALL be the leaf reached by following node bits from root; all-zero state gives way 0.
REQ-018 Touching a way SHALL set each node bit on its path to point away from that way; other bits unchanged.
REQ-019 FSM states SHALL be RUN and SWEEP; flush in RUN -> SWEEP, sweep counter to 0.
REQ-020 In SWEEP one set per cycle SHALL be cleared to zero, counter incrementing; after set SETS-1 cleared -> RUN next cycle (SWEEP lasts exactly SETS cycles).
REQ-021 flush during SWEEP SHALL restart the counter at 0.
REQ-022 busy SHALL be 1 exactly while in SWEEP.
REQ-023 vic_req_ready SHALL equal ~busy, combinationally.
REQ-024 Accepted victim request (valid & ready, cycle N) SHALL produce vic_resp_valid=1 for exactly one cycle at N+1 with vic_resp_way computed from the state at cycle N.
REQ-025 The victim way SHALL be touched in the set state at the edge ending cycle N.
REQ-026 hit_valid in RUN SHALL touch hit_way in hit_set at the edge ending that cycle (no back-pressure); hit_valid in SWEEP SHALL be dropped.
REQ-027 Hit and accepted victim in same cycle, same set: victim chosen from pre-update state; victim touch applied first, hit touch applied on top.
REQ-028 Hit and victim to different sets same cycle: both updates applied independently.
REQ-029 A response pending when flush arrives SHALL still be delivered at N+1.

Reset
REQ-030 Reset SHALL clear all set states to 0, FSM to RUN, counter to 0, vic_resp_valid=0, vic_resp_way=0, busy=0, vic_req_ready=1 after release.
REQ-031 Reset during SWEEP SHALL abort it; no further clearing cycles.

Configuration
REQ-032 Macro PLRU_CTRL_INVALID_FIRST_EN defined: if vic_req_vmask has any 0 bit, victim SHALL be lowest-index invalid way instead of tree result, still touched per REQ-025.
REQ-033 Macro undefined: vic_req_vmask SHALL be ignored; victim always tree result.

Structure
REQ-034 Shared package plru_pkg SHALL hold PLRU_WAYS=16, PLRU_WAY_W=4, PLRU_NODES=15, FSM state enum, and victim/touch functions.
REQ-035 One combinational sub-module plru_tree16_calc SHALL compute victim way and touched next-state from a 15-bit state.

Verification
REQ-036 Reset, vic req set 3 -> resp way 0 at N+1; repeat set 3 -> way 8, then 4, then 12.
REQ-037 Hit set 5 way 0, then vic req set 5 -> way 8; same-cycle hit set 5 way 8 plus vic set 5 -> resp way 0, next vic -> way 4.
REQ-038 Touch sets 0 and SETS-1, flush -> busy for exactly SETS cycles, ready=0, hits dropped; afterwards vic set SETS-1 -> way 0.
REQ-039 Flush at sweep cycle 10 -> busy totals 10+SETS cycles; rst_n low mid-sweep -> busy=0 immediately.
REQ-040 With PLRU_CTRL_INVALID_FIRST_EN, vmask=16'hFFF7 -> way 3; vmask=16'hFFFF -> tree result.
